// File: rtl/memory_read_responder_pkg.sv
// Shared types for the memory read responder: the response record carried
// through the fixed-latency delay line.
package mpt_pkg;

  // Response data width; the responder's DATA_WIDTH must match this.
  localparam int MPT_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      valid;
    logic [MPT_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } mem_rsp_t;

  localparam mem_rsp_t MEM_RSP_IDLE = '{valid: 1'b0, rdata: '0, err: 1'b0};

endpackage

// File: rtl/memory_read_responder_if.sv
// Request/response bus between a memory master and the read responder.
interface memory_read_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_gnt;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_we;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_valid, mem_rdata
  );
endinterface

// File: rtl/memory_read_responder_delay_line.sv
// Fixed-depth shift register of response records; a synchronous clear drops
// everything in flight.
module mem_rsp_delay_line
  import mpt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  mem_rsp_t i_rsp,
  output mem_rsp_t o_rsp
);

  mem_rsp_t r_stage [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= MEM_RSP_IDLE;
    end else begin
      r_stage[0] <= i_rsp;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_rsp = r_stage[DEPTH-1];

endmodule

// File: rtl/memory_read_responder.sv
// Word-array memory slave: accepts one request per cycle under a credit limit
// and answers each after a fixed latency, in grant order.
module memory_read_responder
  import mpt_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DEPTH       = 1024,
  parameter int READ_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  memory_read_responder_if.slave   memory_slave,
  input  logic                     gnt_stall_i,
  output logic                     err_o
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(BE_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W-1:0]                   w_idx;
  logic [ADDR_WIDTH-OFFS_W-IDX_W-1:0] w_idx_hi;
  logic                               w_in_range;
  logic                               w_unused_addr_lsb;
  logic                               w_gnt;
  logic                               w_acc;
  logic                               w_rsp_valid;
  mem_rsp_t                           w_rsp_in;
  mem_rsp_t                           w_rsp_out;
  logic [CNT_W-1:0]                   r_outstanding;
  logic [DATA_WIDTH-1:0]              r_mem [MEM_DEPTH];

  // Any set bit above the word index puts the access outside the array.
  assign w_idx             = memory_slave.mem_addr[OFFS_W +: IDX_W];
  assign w_idx_hi          = memory_slave.mem_addr[ADDR_WIDTH-1 : OFFS_W+IDX_W];
  assign w_in_range        = (w_idx_hi == '0);
  assign w_unused_addr_lsb = ^memory_slave.mem_addr[OFFS_W-1:0];

  assign w_gnt = !rst_i && memory_slave.mem_req && !gnt_stall_i &&
                 (r_outstanding < MAX_CNT);
  assign w_acc = memory_slave.mem_req && w_gnt;
  assign memory_slave.mem_gnt = w_gnt;

  always_ff @(posedge clk_i) begin
    if (w_acc && memory_slave.mem_we && w_in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (memory_slave.mem_be[b])
          r_mem[w_idx][b*8 +: 8] <= memory_slave.mem_wdata[b*8 +: 8];
      end
    end
  end

  // Read data is captured at the grant edge, before any write of a later grant.
  always_comb begin
    w_rsp_in = MEM_RSP_IDLE;
    if (w_acc) begin
      w_rsp_in.valid = 1'b1;
      w_rsp_in.err   = !w_in_range;
      if (!memory_slave.mem_we && w_in_range) w_rsp_in.rdata = r_mem[w_idx];
    end
  end

  mem_rsp_delay_line #(
    .DEPTH (READ_LATENCY)
  ) u_delay_line (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_rsp (w_rsp_in),
    .o_rsp (w_rsp_out)
  );

  assign w_rsp_valid            = w_rsp_out.valid && !rst_i;
  assign memory_slave.mem_valid = w_rsp_valid;
  assign memory_slave.mem_rdata = w_rsp_valid ? w_rsp_out.rdata : '0;
  assign err_o                  = w_rsp_valid && w_rsp_out.err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else if (w_acc && !w_rsp_valid) begin
      r_outstanding <= r_outstanding + CNT_W'(1);
    end else if (!w_acc && w_rsp_valid) begin
      r_outstanding <= r_outstanding - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_memory_read_responder.sv
// Scoreboard bench: instance A uses default parameters, instance B runs a
// single-credit, latency-3 configuration.
module tb_memory_read_responder;

  localparam int LAT_A = 2;
  localparam int MAX_A = 4;
  localparam int DEP_A = 1024;
  localparam int LAT_B = 3;
  localparam int MAX_B = 1;
  localparam int DEP_B = 16;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic stall_a = 1'b0;
  logic stall_b = 1'b0;
  logic err_a;
  logic err_b;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [31:0] model_a [DEP_A];
  int cyc = 0, n_cmp = 0, n_err = 0;
  int out_a = 0, out_b = 0, last_gb = -1, b_grants = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  memory_read_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_if ();
  memory_read_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b_if ();

  memory_read_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEP_A),
    .READ_LATENCY(LAT_A), .MAX_OUTSTANDING(MAX_A)
  ) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .memory_slave(a_if),
    .gnt_stall_i(stall_a), .err_o(err_a)
  );

  memory_read_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEP_B),
    .READ_LATENCY(LAT_B), .MAX_OUTSTANDING(MAX_B)
  ) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .memory_slave(b_if),
    .gnt_stall_i(stall_b), .err_o(err_b)
  );

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Instance A monitor: gnt model, response scoreboard, memory model.
  always @(negedge clk_i) begin
    exp_t        e;
    logic [29:0] idx;
    logic        inr;
    if (rst_i) begin
      out_a = 0;
      chk_val("a_rst_gnt", a_if.mem_gnt, 0);
      chk_val("a_rst_valid", a_if.mem_valid, 0);
      chk_val("a_rst_rdata", a_if.mem_rdata, 0);
      chk_val("a_rst_err", err_a, 0);
    end else begin
      chk_val("a_gnt", a_if.mem_gnt, a_if.mem_req && !stall_a && (out_a < MAX_A));
      if (a_if.mem_valid) begin
        if (sb_a.size() == 0) begin
          chk_val("a_unexpected_valid", a_if.mem_valid, 0);
        end else begin
          e = sb_a.pop_front();
          chk_val("a_rdata", a_if.mem_rdata, e.data);
          chk_val("a_err", err_a, e.err);
          chk_val("a_latency", cyc, e.due);
        end
      end else begin
        chk_val("a_idle_rdata", a_if.mem_rdata, 0);
        chk_val("a_idle_err", err_a, 0);
      end
      if (a_if.mem_req && a_if.mem_gnt) begin
        idx    = a_if.mem_addr[31:2];
        inr    = (idx < DEP_A);
        e.due  = cyc + LAT_A;
        e.err  = !inr;
        e.data = (!a_if.mem_we && inr) ? model_a[idx[9:0]] : 32'h0;
        if (a_if.mem_we && inr)
          for (int b = 0; b < 4; b++)
            if (a_if.mem_be[b]) model_a[idx[9:0]][b*8 +: 8] = a_if.mem_wdata[b*8 +: 8];
        sb_a.push_back(e);
      end
      out_a = out_a + int'(a_if.mem_req && a_if.mem_gnt) - int'(a_if.mem_valid);
    end
  end

  // Instance B monitor: one credit and no same-cycle credit return, so grants
  // are spaced LAT_B+1 cycles apart under continuous request.
  always @(negedge clk_i) begin
    exp_t        e;
    logic [29:0] idx;
    if (rst_i) begin
      out_b   = 0;
      last_gb = -1;
      chk_val("b_rst_gnt", b_if.mem_gnt, 0);
      chk_val("b_rst_valid", b_if.mem_valid, 0);
    end else begin
      chk_val("b_gnt", b_if.mem_gnt, b_if.mem_req && !stall_b && (out_b < MAX_B));
      if (b_if.mem_valid) begin
        if (sb_b.size() == 0) begin
          chk_val("b_unexpected_valid", b_if.mem_valid, 0);
        end else begin
          e = sb_b.pop_front();
          chk_val("b_rdata", b_if.mem_rdata, e.data);
          chk_val("b_err", err_b, e.err);
          chk_val("b_latency", cyc, e.due);
        end
      end
      if (b_if.mem_req && b_if.mem_gnt) begin
        idx    = b_if.mem_addr[31:2];
        e.due  = cyc + LAT_B;
        e.err  = !(idx < DEP_B);
        e.data = 32'h0;
        sb_b.push_back(e);
        if (last_gb >= 0) chk_val("b_gnt_spacing", cyc - last_gb, LAT_B + 1);
        last_gb = cyc;
        b_grants++;
      end
      out_b = out_b + int'(b_if.mem_req && b_if.mem_gnt) - int'(b_if.mem_valid);
      chk_val("b_outstanding_le_1", out_b <= MAX_B, 1);
    end
  end

  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int gcyc);
    bit got;
    got           = 1'b0;
    gcyc          = -1;
    a_if.mem_req  = 1'b1;
    a_if.mem_we   = we;
    a_if.mem_addr = addr;
    a_if.mem_be   = be;
    a_if.mem_wdata = wd;
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge clk_i);
      if (a_if.mem_gnt) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    chk_val("a_gnt_seen", got, 1);
    @(posedge clk_i);
    #1;
    a_if.mem_req = 1'b0;
  endtask

  initial begin
    int g, g0;
    a_if.mem_req = 1'b1; a_if.mem_we = 1'b0; a_if.mem_addr = '0;
    a_if.mem_be = '0; a_if.mem_wdata = '0;
    b_if.mem_req = 1'b1; b_if.mem_we = 1'b0; b_if.mem_addr = '0;
    b_if.mem_be = '0; b_if.mem_wdata = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    a_if.mem_req = 1'b0;
    b_if.mem_req = 1'b0;

    // full-word write then read back
    a_txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, g);
    a_txn(1'b0, 32'h10, 4'h0, 32'h0, g);

    // byte-enable merge
    a_txn(1'b1, 32'h20, 4'hF, 32'h11223344, g);
    a_txn(1'b1, 32'h20, 4'h2, 32'h0000AA00, g);
    a_txn(1'b0, 32'h20, 4'h0, 32'h0, g);

    // back-to-back bursts
    for (int i = 0; i < 8; i++) a_txn(1'b1, i * 4, 4'hF, 32'hA5000000 | i, g);
    g0 = 0;
    for (int i = 0; i < 8; i++) begin
      a_txn(1'b0, i * 4, 4'h0, 32'h0, g);
      if (i == 0) g0 = g;
    end
    chk_val("a_burst_grant_span", g - g0, 7);

    // out-of-range accesses leave storage alone
    a_txn(1'b1, 32'h1000, 4'hF, 32'h12345678, g);
    a_txn(1'b0, 32'h1000, 4'h0, 32'h0, g);
    a_txn(1'b1, 32'h8000_0010, 4'hF, 32'h0BADF00D, g);
    a_txn(1'b0, 32'h0, 4'h0, 32'h0, g);
    a_txn(1'b0, 32'h10, 4'h0, 32'h0, g);

    // stall holds off grant
    stall_a = 1'b1;
    a_if.mem_req = 1'b1; a_if.mem_we = 1'b0; a_if.mem_addr = 32'h14;
    repeat (6) begin
      @(negedge clk_i);
      chk_val("a_stall_gnt", a_if.mem_gnt, 0);
    end
    @(posedge clk_i);
    #1;
    stall_a = 1'b0;
    a_txn(1'b0, 32'h14, 4'h0, 32'h0, g);
    repeat (4) @(posedge clk_i);
    #1;

    // reset with two reads in flight
    a_txn(1'b0, 32'h10, 4'h0, 32'h0, g);
    a_txn(1'b0, 32'h14, 4'h0, 32'h0, g);
    rst_i = 1'b1;
    sb_a.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      chk_val("a_post_rst_valid", a_if.mem_valid, 0);
    end
    @(posedge clk_i);
    #1;
    a_txn(1'b0, 32'h10, 4'h0, 32'h0, g);

    // single-credit instance under continuous request
    b_if.mem_req = 1'b1; b_if.mem_we = 1'b1; b_if.mem_addr = 32'h4;
    b_if.mem_be = 4'hF; b_if.mem_wdata = 32'hCAFE0001;
    repeat (16) @(posedge clk_i);
    #1;
    b_if.mem_req = 1'b0;
    chk_val("b_grant_count", b_grants, 4);

    repeat (10) @(posedge clk_i);
    chk_val("a_drain", sb_a.size(), 0);
    chk_val("b_drain", sb_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
